// File: rtl/capture_pkg.sv
// Shared constants for the logic-analyzer capture sequencer: state codes,
// register offsets within the bus window, and host command values.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE             = 3'd0,
        ST_MOVE_TO_POSITION = 3'd1,
        ST_IN_POSITION      = 3'd2,
        ST_CAPTURING        = 3'd3,
        ST_CAPTURED         = 3'd4
    } cap_state_e;

    localparam logic [1:0] REG_STATE         = 2'd0;
    localparam logic [1:0] REG_TRIGGER_LOC   = 2'd1;
    localparam logic [1:0] REG_READ_POINTER  = 2'd2;
    localparam logic [1:0] REG_WRITE_POINTER = 2'd3;

    localparam logic [15:0] CMD_ABORT = 16'd0;
    localparam logic [15:0] CMD_START = 16'd1;

endpackage

// File: rtl/capture_controller.sv
// Capture sequencer: drives sample-buffer write enable/address so that exactly
// SAMPLE_DEPTH samples are kept around a trigger, with a 4-register bus window.
module capture_controller
    import capture_pkg::*;
#(
    parameter int BASE_ADDR    = 0,
    parameter int SAMPLE_DEPTH = 1024,
    parameter int ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trig,
    input  logic [15:0]           addr_i,
    input  logic [15:0]           wdata_i,
    input  logic [15:0]           rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [15:0]           addr_o,
    output logic [15:0]           wdata_o,
    output logic [15:0]           rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_waddr
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TL_MAX  = ADDR_WIDTH'(SAMPLE_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] TL_RST  = ADDR_WIDTH'(SAMPLE_DEPTH / 2);

    cap_state_e            r_state;
    cap_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_rp;
    logic [ADDR_WIDTH-1:0] r_tl;
    logic [ADDR_WIDTH-1:0] w_wp_nxt;
    logic [ADDR_WIDTH-1:0] w_rp_nxt;
    logic [ADDR_WIDTH-1:0] w_tl_nxt;

    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_rw;
    logic        r_valid;

    logic [15:0] w_off;
    logic        w_in_win;
    logic        w_reg_wr;
    logic        w_reg_rd;
    logic        w_cfg_ok;
    logic        w_we;
    logic        w_wrap_done;
    logic [15:0] w_reg_rdata;

    function automatic logic [ADDR_WIDTH-1:0] sat_tl(input logic [15:0] v);
        if ({16'd0, v} > 32'(SAMPLE_DEPTH - 1)) begin
            return TL_MAX;
        end
        return v[ADDR_WIDTH-1:0];
    endfunction

    // Addresses below BASE_ADDR wrap to large offsets and fall outside the window.
    assign w_off    = addr_i - 16'(BASE_ADDR);
    assign w_in_win = (w_off < 16'd4);
    assign w_reg_wr = valid_i & rw_i & w_in_win;
    assign w_reg_rd = valid_i & ~rw_i & w_in_win;
    assign w_cfg_ok = (r_state == ST_IDLE) || (r_state == ST_CAPTURED);

    assign w_we = (r_state == ST_MOVE_TO_POSITION) ||
                  (r_state == ST_IN_POSITION) ||
                  (r_state == ST_CAPTURING);
    assign w_wrap_done = (r_wp == (r_rp - PTR_ONE));

    assign buf_we    = w_we;
    assign buf_waddr = r_wp;

    always_comb begin
        w_state_nxt = r_state;
        w_wp_nxt    = r_wp;
        w_rp_nxt    = r_rp;
        w_tl_nxt    = r_tl;

        if (w_we) begin
            w_wp_nxt = r_wp + PTR_ONE;
        end

        case (r_state)
            ST_MOVE_TO_POSITION: begin
                if (r_wp == (r_tl - PTR_ONE)) begin
                    w_state_nxt = ST_IN_POSITION;
                end
            end
            ST_IN_POSITION: begin
                if (trig) begin
                    w_state_nxt = w_wrap_done ? ST_CAPTURED : ST_CAPTURING;
                end else begin
                    w_rp_nxt = r_rp + PTR_ONE;
                end
            end
            ST_CAPTURING: begin
                if (w_wrap_done) begin
                    w_state_nxt = ST_CAPTURED;
                end
            end
            default: ;
        endcase

        // Host commands take precedence over the sequencer's own transitions.
        if (w_reg_wr) begin
            case (w_off[1:0])
                REG_STATE: begin
                    if (wdata_i == CMD_ABORT) begin
                        w_state_nxt = ST_IDLE;
                        w_wp_nxt    = r_wp;
                        w_rp_nxt    = r_rp;
                    end else if ((wdata_i == CMD_START) && w_cfg_ok) begin
                        w_state_nxt = (r_tl == '0) ? ST_IN_POSITION : ST_MOVE_TO_POSITION;
                        w_wp_nxt    = '0;
                        w_rp_nxt    = '0;
                    end
                end
                REG_TRIGGER_LOC: begin
                    if (w_cfg_ok) begin
                        w_tl_nxt = sat_tl(wdata_i);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_tl    <= TL_RST;
        end else begin
            r_state <= w_state_nxt;
            r_wp    <= w_wp_nxt;
            r_rp    <= w_rp_nxt;
            r_tl    <= w_tl_nxt;
        end
    end

    always_comb begin
        w_reg_rdata = 16'd0;
        case (w_off[1:0])
            REG_STATE:         w_reg_rdata = 16'(r_state);
            REG_TRIGGER_LOC:   w_reg_rdata = 16'(r_tl);
            REG_READ_POINTER:  w_reg_rdata = 16'(r_rp);
            REG_WRITE_POINTER: w_reg_rdata = 16'(r_wp);
            default:           w_reg_rdata = 16'd0;
        endcase
    end

    // Bus chain stage: every field registered once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 16'd0;
            r_wdata <= 16'd0;
            r_rdata <= 16'd0;
            r_rw    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_rdata <= w_reg_rd ? w_reg_rdata : rdata_i;
            r_rw    <= rw_i;
            r_valid <= valid_i;
        end
    end

    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign rdata_o = r_rdata;
    assign rw_o    = r_rw;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller with SAMPLE_DEPTH=8: register table, directed
// capture corner cases and randomized captures against a closed-form model.
module tb_capture_controller;
    import capture_pkg::*;

    localparam int D    = 8;
    localparam int BASE = 16;
    localparam int AW   = $clog2(D);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trig = 1'b0;
    logic [15:0]   addr_i = 16'd0;
    logic [15:0]   wdata_i = 16'd0;
    logic [15:0]   rdata_i = 16'd0;
    logic          rw_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [15:0]   addr_o;
    logic [15:0]   wdata_o;
    logic [15:0]   rdata_o;
    logic          rw_o;
    logic          valid_o;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;

    int total = 0;
    int bad   = 0;

    capture_controller #(
        .BASE_ADDR   (BASE),
        .SAMPLE_DEPTH(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_i  (rdata_i),
        .rw_i     (rw_i),
        .valid_i  (valid_i),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .rdata_o  (rdata_o),
        .rw_o     (rw_o),
        .valid_o  (valid_o),
        .buf_we   (buf_we),
        .buf_waddr(buf_waddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    wr;
        int    off;
        int    wdata;
        int    exp;
        string nm;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int off, input int data);
        valid_i = 1'b1;
        rw_i    = 1'b1;
        addr_i  = 16'(BASE + off);
        wdata_i = 16'(data);
        tick();
        valid_i = 1'b0;
        rw_i    = 1'b0;
    endtask

    task automatic bus_read(input int off, output logic [15:0] d);
        valid_i = 1'b1;
        rw_i    = 1'b0;
        addr_i  = 16'(BASE + off);
        tick();
        d       = rdata_o;
        valid_i = 1'b0;
    endtask

    // Model: writes run at addresses 0,1,2,... from START. A trigger counts
    // only at write index >= tl, so the effective trigger index is t; the run
    // then lasts t - tl + D writes and the oldest sample sits at t - tl.
    task automatic run_capture(input int tl, input int k, input bit pulse, input string nm);
        int          t;
        int          exp_n;
        int          exp_rp;
        int          exp_code;
        int          code;
        int          last;
        int          n;
        int          trig_addr;
        logic [15:0] d;
        t        = pulse ? k : ((k > tl) ? k : tl);
        exp_n    = t - tl + D;
        exp_rp   = (t - tl) % D;
        exp_code = 0;
        if (tl > 0) exp_code = exp_code * 10 + 1;
        exp_code = exp_code * 10 + 2;
        if (tl != D - 1) exp_code = exp_code * 10 + 3;
        exp_code = exp_code * 10 + 4;

        bus_write(1, tl);
        bus_write(0, 1);
        n         = 0;
        code      = 0;
        last      = -1;
        trig_addr = -1;
        valid_i   = 1'b1;
        rw_i      = 1'b0;
        addr_i    = 16'(BASE);
        while (buf_we === 1'b1 && n < 64) begin
            if (buf_waddr !== AW'(n % D)) begin
                chk({nm, "_waddr"}, 64'(buf_waddr), 64'(n % D));
            end
            trig = pulse ? (n == k) : (n >= k);
            if (n == t) trig_addr = int'(buf_waddr);
            tick();
            if (int'(rdata_o[2:0]) != last) begin
                last = int'(rdata_o[2:0]);
                code = code * 10 + last;
            end
            n++;
        end
        tick();
        if (int'(rdata_o[2:0]) != last) code = code * 10 + int'(rdata_o[2:0]);
        trig    = 1'b0;
        valid_i = 1'b0;
        chk({nm, "_nwrites"}, 64'(n), 64'(exp_n));
        chk({nm, "_we_captured"}, 64'(buf_we), 64'd0);
        chk({nm, "_stateseq"}, 64'(code), 64'(exp_code));
        chk({nm, "_trigaddr"}, 64'(trig_addr), 64'((exp_rp + tl) % D));
        bus_read(2, d);
        chk({nm, "_rp"}, 64'(d), 64'(exp_rp));
        bus_read(3, d);
        chk({nm, "_wp"}, 64'(d), 64'(exp_rp));
        bus_read(0, d);
        chk({nm, "_state"}, 64'(d), 64'(ST_CAPTURED));
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] ra, rw16, rr;
        logic        rrw;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_outputs", {addr_o, wdata_o, rdata_o, 13'd0, rw_o, valid_o, buf_we}, 64'd0);
        chk("rst_waddr", 64'(buf_waddr), 64'd0);

        // Register access table
        rdata_i = 16'hBEEF;
        tbl.push_back('{0, 0, 0, 0, "rd_state_rst"});
        tbl.push_back('{0, 1, 0, 4, "rd_tl_rst"});
        tbl.push_back('{0, 2, 0, 0, "rd_rp_rst"});
        tbl.push_back('{0, 3, 0, 0, "rd_wp_rst"});
        tbl.push_back('{1, 1, 9, 0, "wr_tl_9"});
        tbl.push_back('{0, 1, 0, 7, "rd_tl_sat"});
        tbl.push_back('{1, 1, 2, 0, "wr_tl_2"});
        tbl.push_back('{0, 1, 0, 2, "rd_tl_2"});
        tbl.push_back('{1, 1, 16'hFFFF, 0, "wr_tl_ffff"});
        tbl.push_back('{0, 1, 0, 7, "rd_tl_sat2"});
        tbl.push_back('{1, 0, 5, 0, "wr_state_bad"});
        tbl.push_back('{0, 0, 0, 0, "rd_state_still0"});
        tbl.push_back('{1, 2, 3, 0, "wr_rp_ro"});
        tbl.push_back('{0, 2, 0, 0, "rd_rp_ro"});
        tbl.push_back('{0, 4, 0, 16'hBEEF, "rd_above_win"});
        tbl.push_back('{0, -1, 0, 16'hBEEF, "rd_below_win"});
        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].off, tbl[i].wdata);
            end else begin
                bus_read(tbl[i].off, d);
                chk(tbl[i].nm, 64'(d), 64'(tbl[i].exp));
            end
        end

        // Bus chain passthrough with 1-cycle latency
        for (int i = 0; i < 4; i++) begin
            ra      = 16'($urandom);
            rw16    = 16'($urandom);
            rr      = 16'($urandom);
            rrw     = 1'($urandom);
            addr_i  = ra;
            wdata_i = rw16;
            rdata_i = rr;
            rw_i    = rrw;
            valid_i = 1'b0;
            tick();
            chk("bus_pass", {addr_o, wdata_o, rdata_o, rw_o, valid_o}, {ra, rw16, rr, rrw, 1'b0});
        end
        rw_i    = 1'b0;
        wdata_i = 16'd0;

        // Directed capture corner cases
        run_capture(3, 10, 1'b1, "normal");
        run_capture(0, 5, 1'b1, "tl0");
        run_capture(7, 9, 1'b1, "tl7");
        run_capture(5, 0, 1'b0, "early");

        for (int r = 0; r < 10; r++) begin
            run_capture(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 20)), 1'b0, "rand");
        end

        // ABORT during CAPTURING; trigger_loc write there is ignored
        bus_write(1, 2);
        bus_write(0, 1);
        trig = 1'b1;
        repeat (4) tick();
        trig = 1'b0;
        bus_read(0, d);
        chk("abort_pre_state", 64'(d), 64'(ST_CAPTURING));
        bus_write(1, 6);
        bus_write(0, 0);
        chk("abort_we", 64'(buf_we), 64'd0);
        bus_read(0, d);
        chk("abort_state", 64'(d), 64'(ST_IDLE));
        bus_read(1, d);
        chk("abort_tl_kept", 64'(d), 64'd2);
        bus_read(2, d);
        chk("abort_rp_hold", 64'(d), 64'd0);
        bus_read(3, d);
        chk("abort_wp_hold", 64'(d), 64'd6);

        // START in IN_POSITION is ignored
        bus_write(1, 1);
        bus_write(0, 1);
        tick();
        bus_write(0, 1);
        bus_read(0, d);
        chk("start_ignored_state", 64'(d), 64'(ST_IN_POSITION));
        bus_read(2, d);
        chk("start_ignored_rp", 64'(d), 64'd2);
        bus_read(3, d);
        chk("start_ignored_wp", 64'(d), 64'd4);
        bus_write(0, 0);

        // ABORT in the same cycle as trig
        bus_write(0, 1);
        tick();
        trig = 1'b1;
        bus_write(0, 0);
        trig = 1'b0;
        chk("abort_trig_we", 64'(buf_we), 64'd0);
        bus_read(0, d);
        chk("abort_trig_state", 64'(d), 64'(ST_IDLE));

        // Asynchronous reset mid-CAPTURING
        bus_write(1, 2);
        bus_write(0, 1);
        trig = 1'b1;
        repeat (3) tick();
        trig    = 1'b0;
        valid_i = 1'b1;
        rw_i    = 1'b0;
        addr_i  = 16'(BASE + 3);
        wdata_i = 16'h1234;
        tick();
        chk("arst_pre_we", 64'(buf_we), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_outputs", {addr_o, wdata_o, rdata_o, 13'd0, rw_o, valid_o, buf_we}, 64'd0);
        chk("arst_waddr", 64'(buf_waddr), 64'd0);
        valid_i = 1'b0;
        addr_i  = 16'd0;
        wdata_i = 16'd0;
        tick();
        rst = 1'b0;
        bus_read(0, d);
        chk("arst_state", 64'(d), 64'(ST_IDLE));
        bus_read(1, d);
        chk("arst_tl", 64'(d), 64'(D / 2));
        rdata_i = 16'h5A5A;
        bus_read(40, d);
        chk("arst_passthru", 64'(d), 64'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_controller.md
# capture_controller

Sequencing FSM for the logic-analyzer core. It sits on the register bus chain next to the trigger block and consumes its `trig` output. It drives write-enable and write-address for the sample buffer so that exactly `SAMPLE_DEPTH` samples are kept, with a programmable number of them preceding the trigger. The host arms it, polls its state, and reads back the buffer start pointer.

## Interface
- `BASE_ADDR`, 0: first bus address of the 4-register window.
- `SAMPLE_DEPTH`, 1024: sample buffer depth; power of two, 4..32768.
- `ADDR_WIDTH`, $clog2(SAMPLE_DEPTH): buffer address width (derived, not overridden).

- `clk`  in  1  sole clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `trig`  in  1  trigger from trigger block; sampled each cycle.
- `addr_i`, `wdata_i`, `rdata_i`  in  16 each  bus chain input.
- `rw_i`, `valid_i`  in  1 each  bus chain input (rw 1 = write).
- `addr_o`, `wdata_o`, `rdata_o`  out  16 each  registered bus chain output.
- `rw_o`, `valid_o`  out  1 each  registered bus chain output.
- `buf_we`  out  1  sample buffer write enable.
- `buf_waddr`  out  ADDR_WIDTH  sample buffer write address (= write pointer `wp`).

## Operation
- Registers (offset from BASE_ADDR):
  - +0 `state`: reads the state code. Writing 1 = START, accepted only in IDLE or CAPTURED. Writing 0 = ABORT, accepted in any state. Other values are ignored.
  - +1 `trigger_loc`: R/W; the number of pre-trigger samples. A write is accepted only in IDLE or CAPTURED. Values above SAMPLE_DEPTH-1 saturate to SAMPLE_DEPTH-1.
  - +2 `read_pointer` (`rp`): RO; buffer address of the oldest sample.
  - +3 `write_pointer` (`wp`): RO.
- Reads outside the window pass `rdata_i` through. Writes to RO registers are ignored.
- States: IDLE=0, MOVE_TO_POSITION=1, IN_POSITION=2, CAPTURING=3, CAPTURED=4.
- `buf_we` = 1 exactly in states 1–3; it is a combinational decode of the state register. Each such cycle writes at `wp`, then `wp <= wp+1 mod SAMPLE_DEPTH`.
- START: `wp<=0`, `rp<=0`. The next state is MOVE_TO_POSITION, or IN_POSITION if `trigger_loc==0`.
- MOVE_TO_POSITION:
  - `trig` is ignored.
  - `rp` holds.
  - Leave for IN_POSITION on the cycle that writes at `wp == trigger_loc-1`.
- IN_POSITION, `trig`=0: `rp <= rp+1 mod SAMPLE_DEPTH`, so the distance `wp-rp` stays equal to `trigger_loc`.
- IN_POSITION, `trig`=1:
  - The trigger sample is written at `wp`, which equals `rp+trigger_loc`.
  - `rp` freezes from this cycle on.
  - Next state is CAPTURING, or CAPTURED if `wp == rp-1 mod SAMPLE_DEPTH` (the case `trigger_loc == SAMPLE_DEPTH-1`).
- CAPTURING: go to CAPTURED on the cycle that writes at `wp == rp-1 mod SAMPLE_DEPTH`. The buffer then holds SAMPLE_DEPTH samples starting at `rp`.
- CAPTURED: holds with `buf_we`=0; `wp` and `rp` frozen.
- ABORT: next state IDLE; pointers hold their values.
- A bus write to `state` overrides any FSM transition in the same cycle.
- Pointer arithmetic is unsigned ADDR_WIDTH-bit and wraps naturally. Bus reads zero-extend to 16 bits.

## Timing
- Reset (async assert, release synchronous to `clk`):
  - state IDLE, `wp`=0, `rp`=0, `trigger_loc`=SAMPLE_DEPTH/2.
  - All bus outputs 0, `buf_we`=0.
- Reset mid-capture drops `buf_we` immediately, without waiting for a clock.
- Bus passes through with 1-cycle latency on every field. Read data for an in-window read appears on `rdata_o` 1 cycle after `valid_i`.
- A register write takes effect at the same edge that registers the bus transfer. The new state is visible to a read issued 1 cycle later.
- START edge: `buf_we` rises the following cycle with `buf_waddr`=0.
- `trig` is sampled at the same edge as the write it qualifies; no extra pipeline stage.
- Time from START to CAPTURED: exactly SAMPLE_DEPTH writing cycles if the trigger arrives during MOVE_TO_POSITION or at the first IN_POSITION cycle. Otherwise, more cycles.

## Structure
- Shared package/header `capture_pkg` holds:
  - the state codes;
  - register offsets (STATE=0, TRIGGER_LOC=1, READ_POINTER=2, WRITE_POINTER=3);
  - command values (ABORT=0, START=1).
- The host driver and other LA blocks use the same constants.
- No sub-module: FSM, pointers and register file together form one flat module.

## Test plan
All scenarios use SAMPLE_DEPTH=8.
- Reset check: after reset, read +0 → 0 and +1 → 4. Write 9 to +1, read → 7.
- Normal capture:
  - Set `trigger_loc`=3, START, pulse `trig` 10 cycles after START.
  - Required: state sequence 1→2→3→4.
  - Trigger sample at address `rp+3`.
  - Exactly 8 writes after the last wrap, `buf_we`=0 in CAPTURED.
  - Read +2 matches the expected `rp`.
- `trigger_loc` extremes:
  - With 0: START goes straight to IN_POSITION; trigger sample at `rp`.
  - With 7: a trig pulse goes 2→4 directly; `buf_we` drops next cycle.
- Early trigger: `trig` held high from START with `trigger_loc`=5 → ignored during MOVE_TO_POSITION, then fires on the first IN_POSITION cycle; CAPTURED after exactly 8 writes.
- Abort and priority:
  - ABORT during CAPTURING → IDLE, `buf_we`=0.
  - A START issued in IN_POSITION and a `trigger_loc` write issued in CAPTURING are both ignored.
  - ABORT in the same cycle as trig wins.
- Async reset asserted mid-CAPTURING, between clock edges → `buf_we` and all outputs go to reset values at once. Bus reads outside the window pass `rdata_i` through unchanged.
